// File: rtl/dump_reader_if.sv
// Signal bundle between the dump reader, the channel RAM read port, the UART TX
// and the cmd/config block. slave = dump_reader side, master = environment side.
interface dump_reader_if #(
  parameter int unsigned LOG2 = 9
);
  logic            dump;
  logic [LOG2-1:0] last_waddr;
  logic [LOG2-1:0] raddr;
  logic            ren;
  logic [7:0]      rdata;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            tx_done;
  logic            busy;
  logic            dump_done;

  modport slave (
    input  dump, last_waddr, rdata, tx_done,
    output raddr, ren, tx_data, trmt, busy, dump_done
  );

  modport master (
    output dump, last_waddr, rdata, tx_done,
    input  raddr, ren, tx_data, trmt, busy, dump_done
  );
endinterface

// File: rtl/dump_reader.sv
// Reads one channel RAM oldest-sample-first out of the circular capture buffer
// and feeds each byte to the UART TX via the trmt/tx_done handshake.
module dump_reader #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  dump_reader_if.slave       bus
);

  typedef enum logic [1:0] {StIdle, StRead, StLatch, StWaitTx} state_t;

  localparam logic [LOG2-1:0] LastAddr = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] One      = LOG2'(1);

  state_t          r_state, w_state_nxt;
  logic [LOG2-1:0] r_raddr, w_raddr_nxt;
  logic [LOG2-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_trmt, w_trmt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_dump_done, w_dump_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_raddr     <= '0;
      r_cnt       <= '0;
      r_tx_data   <= '0;
      r_trmt      <= 1'b0;
      r_busy      <= 1'b0;
      r_dump_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_raddr     <= w_raddr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_trmt      <= w_trmt_nxt;
      r_busy      <= w_busy_nxt;
      r_dump_done <= w_dump_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_raddr_nxt     = r_raddr;
    w_cnt_nxt       = r_cnt;
    w_tx_data_nxt   = r_tx_data;
    w_trmt_nxt      = 1'b0;
    w_busy_nxt      = r_busy;
    w_dump_done_nxt = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.dump) begin
          // Oldest sample sits just after the last write, wrapping at ENTRIES.
          w_raddr_nxt = (bus.last_waddr == LastAddr) ? '0 : bus.last_waddr + One;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = StRead;
        end
      end
      StRead: begin
        w_state_nxt = StLatch;
      end
      StLatch: begin
        w_tx_data_nxt = bus.rdata;
        w_trmt_nxt    = 1'b1;
        w_raddr_nxt   = (r_raddr == LastAddr) ? '0 : r_raddr + One;
        w_state_nxt   = StWaitTx;
      end
      StWaitTx: begin
        // tx_done seen alongside trmt belongs to the previous byte.
        if (bus.tx_done && !r_trmt) begin
          if (r_cnt == LastAddr) begin
            w_state_nxt     = StIdle;
            w_busy_nxt      = 1'b0;
            w_dump_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + One;
            w_state_nxt = StRead;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign bus.raddr     = r_raddr;
  assign bus.ren       = (r_state == StRead);
  assign bus.tx_data   = r_tx_data;
  assign bus.trmt      = r_trmt;
  assign bus.busy      = r_busy;
  assign bus.dump_done = r_dump_done;

endmodule

// File: tb/tb_dump_reader.sv
// Directed bench for dump_reader with an 8-entry RAM holding 0x10+i.
module tb_dump_reader;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned LOG2    = 3;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   mon_trmt = 0;
  int   mon_dd   = 0;
  int   snap_trmt;
  int   snap_dd;
  logic [7:0] ram [ENTRIES];

  dump_reader_if #(.LOG2(LOG2)) bus ();

  dump_reader #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ren) bus.rdata <= ram[bus.raddr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.trmt) mon_trmt <= mon_trmt + 1;
      if (bus.dump_done) mon_dd <= mon_dd + 1;
    end
  end

  function automatic logic [7:0] exp_byte(input int idx);
    return 8'(16 + (idx % ENTRIES));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_raddr"}, 32'(bus.raddr), 32'd0);
    check({tag, "_ren"}, 32'(bus.ren), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_trmt"}, 32'(bus.trmt), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_dump_done"}, 32'(bus.dump_done), 32'd0);
  endtask

  // Called at a negedge; dump is sampled by the next posedge (edge N).
  task automatic start_dump(input logic [2:0] lw, input int start);
    bus.dump       = 1'b1;
    bus.last_waddr = lw;
    @(negedge clk);
    bus.dump       = 1'b0;
    bus.last_waddr = ~lw;
    check("n1_ren", 32'(bus.ren), 32'd1);
    check("n1_busy", 32'(bus.busy), 32'd1);
    check("n1_raddr", 32'(bus.raddr), 32'(start));
    @(negedge clk);
    check("n2_ren", 32'(bus.ren), 32'd0);
    check("n2_trmt", 32'(bus.trmt), 32'd0);
    @(negedge clk);
    check("n3_trmt", 32'(bus.trmt), 32'd1);
  endtask

  task automatic wait_trmt(input logic [7:0] exp);
    int w = 0;
    while (!bus.trmt && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("trmt_seen", 32'(bus.trmt), 32'd1);
    check("tx_data", 32'(bus.tx_data), 32'(exp));
  endtask

  // Starts in the trmt cycle; returns in the next trmt cycle (or M+1 if last).
  task automatic handshake(input bit last, input int hold, input bit stale, input bit reissue);
    int cnt;
    if (stale) begin
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check("stale_ignored_ren", 32'(bus.ren), 32'd0);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bus.dump = reissue && (k == 4);
      if (bus.dump) bus.last_waddr = 3'd0;
    end
    bus.dump    = 1'b0;
    bus.tx_done = 1'b1;
    @(negedge clk);
    cnt = 1;
    if (last) begin
      check("m1_dump_done", 32'(bus.dump_done), 32'd1);
      check("m1_busy", 32'(bus.busy), 32'd0);
    end else begin
      check("m1_ren", 32'(bus.ren), 32'd1);
    end
    repeat (hold - 1) begin
      @(negedge clk);
      cnt++;
    end
    bus.tx_done = 1'b0;
    if (!last) begin
      while (!bus.trmt && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check("m3_trmt", 32'(cnt), 32'd3);
    end
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) ram[i] = 8'(16 + i);
    bus.dump       = 1'b0;
    bus.last_waddr = '0;
    bus.tx_done    = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // tx_done while idle must do nothing
    bus.tx_done = 1'b1;
    repeat (2) @(negedge clk);
    bus.tx_done = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_trmt", 32'(bus.trmt), 32'd0);
    check("idle_ren", 32'(bus.ren), 32'd0);

    // A: last_waddr=3, bytes 0x14..0x17,0x10..0x13
    snap_trmt = mon_trmt;
    snap_dd   = mon_dd;
    start_dump(3'd3, 4);
    for (int i = 0; i < 8; i++) begin
      wait_trmt(exp_byte(4 + i));
      handshake(i == 7, 1, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("a_dump_done_one_cycle", 32'(bus.dump_done), 32'd0);
    @(negedge clk);
    check("a_trmt_count", 32'(mon_trmt - snap_trmt), 32'd8);
    check("a_dd_count", 32'(mon_dd - snap_dd), 32'd1);

    // B: last_waddr=ENTRIES-1 starts at 0; tx_done held across READ/LATCH and stale tx_done
    snap_trmt = mon_trmt;
    snap_dd   = mon_dd;
    start_dump(3'd7, 0);
    for (int i = 0; i < 8; i++) begin
      wait_trmt(exp_byte(i));
      handshake(i == 7, (i == 1) ? 3 : 1, i == 2, 1'b0);
    end
    // C: back-to-back dump at M+1, dump reissued mid-dump at byte 3
    start_dump(3'd5, 6);
    for (int i = 0; i < 8; i++) begin
      wait_trmt(exp_byte(6 + i));
      handshake(i == 7, 1, 1'b0, i == 3);
    end
    repeat (2) @(negedge clk);
    check("bc_trmt_count", 32'(mon_trmt - snap_trmt), 32'd16);
    check("bc_dd_count", 32'(mon_dd - snap_dd), 32'd2);

    // D: reset after byte 2's trmt aborts, then a fresh dump restarts cleanly
    snap_trmt = mon_trmt;
    snap_dd   = mon_dd;
    start_dump(3'd1, 2);
    for (int i = 0; i < 2; i++) begin
      wait_trmt(exp_byte(2 + i));
      handshake(1'b0, 1, 1'b0, 1'b0);
    end
    wait_trmt(exp_byte(4));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_trmt_count", 32'(mon_trmt - snap_trmt), 32'd3);
    check("abort_dd_count", 32'(mon_dd - snap_dd), 32'd0);

    snap_trmt = mon_trmt;
    snap_dd   = mon_dd;
    start_dump(3'd1, 2);
    for (int i = 0; i < 8; i++) begin
      wait_trmt(exp_byte(2 + i));
      handshake(i == 7, 1, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);
    check("d_trmt_count", 32'(mon_trmt - snap_trmt), 32'd8);
    check("d_dd_count", 32'(mon_dd - snap_dd), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dump_reader.md
# dump_reader

Readback engine for the logic-analyzer sample RAM. After a capture completes, a host dump command makes this block read all `ENTRIES` samples from one channel RAM in chronological order, oldest first. It starts just after the final capture write address and wraps around the circular buffer. Each byte goes to the UART transmitter through a `trmt`/`tx_done` handshake. It sits between the channel RAMs (read port) and the UART TX, under control of the command/config block.

## Interface
- `ENTRIES`, 384: number of RAM entries (12288 on DE-0); need not be a power of 2.
- `LOG2`, 9: address width; must satisfy `2**LOG2 >= ENTRIES`.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `dump`  in  1  one-cycle start request from cmd/config; ignored unless idle
- `last_waddr`  in  LOG2  RAM address of the final sample written by capture; sampled on accepted `dump`
- `raddr`  out  LOG2  RAM read address (registered)
- `ren`  out  1  RAM read enable; RAM returns `rdata` one clock after `ren`/`raddr`
- `rdata`  in  8  RAM read data
- `tx_data`  out  8  byte to UART TX (registered)
- `trmt`  out  1  one-cycle pulse to start a UART transmission
- `tx_done`  in  1  UART byte complete (pulse or level; only the first high cycle in WAIT_TX counts)
- `busy`  out  1  high from accepted `dump` until the dump completes
- `dump_done`  out  1  one-cycle pulse when the last byte's `tx_done` has been received

## Operation
- Reset values: `raddr`=0, `ren`=0, `tx_data`=0, `trmt`=0, `busy`=0, `dump_done`=0. State is IDLE and the byte counter is 0.
- States:
  - IDLE:
    - On `dump`: set `raddr` to the start address, clear the byte counter, set `busy`, go to READ.
    - Start address is `last_waddr+1`, or 0 if `last_waddr==ENTRIES-1`.
  - READ: `ren`=1 for exactly this cycle at the current `raddr`; go to LATCH.
  - LATCH:
    - Register `rdata` into `tx_data` and set `trmt` for the next cycle.
    - Advance `raddr` with wrap: `ENTRIES-1` goes to 0; do not rely on LOG2 overflow.
    - Go to WAIT_TX.
  - WAIT_TX:
    - Hold until `tx_done`.
    - If the counter is `ENTRIES-1`: go to IDLE, clear `busy`, pulse `dump_done`.
    - Otherwise: increment the counter and go to READ.
- Byte counter width is LOG2; it counts 0 to `ENTRIES-1`. Exactly `ENTRIES` bytes are sent per dump.
- `dump` while `busy` is ignored, with no restart and no counter change.
- `tx_done` outside WAIT_TX is ignored. `tx_done` coincident with `trmt` is treated as stale and ignored: the first WAIT_TX cycle is the one in which `trmt` is high.
- `last_waddr` changes after acceptance have no effect.
- Asserting `rst_n` low mid-dump aborts immediately: all outputs return to reset values, no `dump_done`.

## Timing
- `dump` high at edge N is accepted. READ holds with `ren`=1 in cycle N+1, LATCH in N+2, and `trmt`=1 with valid `tx_data` in N+3.
- `tx_data` is stable from the `trmt` cycle until the next `trmt`.
- `trmt` is high exactly one cycle per byte.
- For a `tx_done` sampled at edge M (not last byte): READ in M+1, next `trmt` in M+3. There are 3 cycles of overhead per byte beyond the UART time.
- For the last byte's `tx_done` at edge M: `dump_done`=1 and `busy`=0 in cycle M+1. A new `dump` is accepted from cycle M+1.
- `raddr` changes only on accepted `dump` and in LATCH. It never equals ENTRIES or above.

## Test plan
- ENTRIES=8, LOG2=3, RAM[i]=0x10+i, `last_waddr`=3, `dump`, `tx_done` returned 10 clocks after each `trmt`:
  - bytes 0x14,0x15,0x16,0x17,0x10,0x11,0x12,0x13 in order;
  - one `dump_done`;
  - 8 `trmt` pulses.
- `last_waddr`=7 (ENTRIES-1): reads start at `raddr`=0; the sequence is 0x10..0x17; `raddr` never reaches 8.
- `dump` reissued mid-dump at byte 3: sequence and count unchanged, single `dump_done`.
- Spurious `tx_done` in IDLE and during READ/LATCH: no extra bytes, no state change.
- `rst_n` low after byte 2's `trmt`:
  - all outputs 0 immediately, no `dump_done`;
  - a subsequent `dump` restarts from `last_waddr+1`.
- Latency check: `dump` at edge N gives `ren` high in N+1 and `trmt` in N+3. Last `tx_done` at edge M gives `dump_done` in M+1; a second `dump` issued at M+1 starts cleanly.
